// File: rtl/puf_ctrl_pkg.sv
// Shared definitions for the PUF challenge sequencer.
//   - puf_state_e : sequencer FSM states, visible on the debug port
//   - DEF_*       : default parameter values
//   - PHASE_W     : phase counter width
//   - CNT_W       : vote / ones counter width
package puf_ctrl_pkg;

  localparam int DEF_CHAL_W        = 32;
  localparam int DEF_SETTLE_CYCLES = 8;
  localparam int DEF_VOTES         = 5;

  localparam int PHASE_W = 8;
  // 4 bits hold up to 15, which covers every legal VOTES value.
  localparam int CNT_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRECHARGE = 3'd1,
    ST_LAUNCH    = 3'd2,
    ST_SAMPLE    = 3'd3,
    ST_RESP      = 3'd4
  } puf_state_e;

endpackage

// File: rtl/puf_resp_sync.sv
// Two-flop synchronizer that brings the arbiter response into the clk domain.
//   clk    : destination clock
//   rst_n  : asynchronous active-low reset, both flops clear to 0
//   d      : asynchronous input (PUF out_Q)
//   q      : synchronized output, two clk edges of latency
module puf_resp_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Drives one challenge into the arbiter PUF array, fires VOTES
// precharge/launch cycles on the shared start net and returns a
// majority-voted response bit plus an all-votes-agree flag.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : challenge request handshake, req_chal payload
//   rsp_valid/rsp_ready : response handshake, rsp_bit / rsp_stable payload
//   puf_chal            : registered challenge bus to the PUF
//   puf_launch          : registered start edge to the PUF in_X / in_Y
//   puf_resp            : PUF out_Q, asynchronous to clk
//   dbg_state           : current FSM state
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. req_ready is 1 only in IDLE; req_valid at other times is
// ignored. rsp_valid, once raised, stays 1 with rsp_bit / rsp_stable held
// until the edge where rsp_ready is also 1; rsp_ready alone does nothing.
module puf_challenge_sequencer
  import puf_ctrl_pkg::*;
#(
  parameter int CHAL_W        = DEF_CHAL_W,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int VOTES         = DEF_VOTES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CHAL_W-1:0] req_chal,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_bit,
  output logic              rsp_stable,
  output logic [CHAL_W-1:0] puf_chal,
  output logic              puf_launch,
  input  logic              puf_resp,
  output puf_state_e        dbg_state
);

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   VOTES_C    = CNT_W'(VOTES);
  localparam logic [CNT_W-1:0]   HALF_C     = CNT_W'(VOTES / 2);

  puf_state_e         state_q, state_d;
  logic [PHASE_W-1:0] phase_q;
  logic [CNT_W-1:0]   vote_q, ones_q;
  logic [CNT_W-1:0]   vote_inc, ones_inc;
  logic               resp_sync;
  logic               accept, rsp_done;

  puf_resp_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (puf_resp),
    .q     (resp_sync)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign dbg_state = state_q;
  assign accept    = req_valid && req_ready;
  assign rsp_done  = (state_q == ST_RESP) && rsp_ready;
  assign vote_inc  = vote_q + CNT_W'(1);
  assign ones_inc  = ones_q + {{(CNT_W-1){1'b0}}, resp_sync};

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (accept)                state_d = ST_PRECHARGE;
      ST_PRECHARGE: if (phase_q == PHASE_LAST) state_d = ST_LAUNCH;
      ST_LAUNCH:    if (phase_q == PHASE_LAST) state_d = ST_SAMPLE;
      ST_SAMPLE:    state_d = (vote_inc == VOTES_C) ? ST_RESP : ST_PRECHARGE;
      ST_RESP:      if (rsp_ready)             state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      vote_q     <= '0;
      ones_q     <= '0;
      puf_chal   <= '0;
      puf_launch <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_bit    <= 1'b0;
      rsp_stable <= 1'b0;
    end else begin
      state_q <= state_d;

      // Phase counter restarts on every state change and only runs in the
      // two timed phases.
      if (state_d != state_q) begin
        phase_q <= '0;
      end else if (state_q == ST_PRECHARGE || state_q == ST_LAUNCH) begin
        phase_q <= phase_q + PHASE_W'(1);
      end else begin
        phase_q <= '0;
      end

      if (accept) begin
        puf_chal <= req_chal;
        vote_q   <= '0;
        ones_q   <= '0;
      end else if (state_q == ST_SAMPLE) begin
        vote_q <= vote_inc;
        ones_q <= ones_inc;
      end

      // Registered from the current state: the start net is high for the
      // SETTLE_CYCLES cycles following LAUNCH entry and falls on the edge
      // that leaves SAMPLE.
      puf_launch <= (state_q == ST_LAUNCH);

      if (state_q == ST_SAMPLE && state_d == ST_RESP) begin
        rsp_valid  <= 1'b1;
        rsp_bit    <= (ones_inc > HALF_C);
        rsp_stable <= (ones_inc == '0) || (ones_inc == VOTES_C);
      end else if (rsp_done) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
module tb_puf_challenge_sequencer;
  import puf_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (defaults) ----------------
  logic        req_valid = 1'b0, req_ready;
  logic [31:0] req_chal = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_bit, rsp_stable;
  logic [31:0] puf_chal;
  logic        puf_launch, puf_resp;
  puf_state_e  dbg_state;

  puf_challenge_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_chal(req_chal),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_bit(rsp_bit), .rsp_stable(rsp_stable),
    .puf_chal(puf_chal), .puf_launch(puf_launch), .puf_resp(puf_resp),
    .dbg_state(dbg_state)
  );

  // ---------------- sweep DUTs (S=3, V=1 and V=15) ----------------
  logic       sw_req_valid = 1'b0;
  logic       a_req_ready, a_rsp_valid, a_rsp_bit, a_rsp_stable, a_launch;
  logic       b_req_ready, b_rsp_valid, b_rsp_bit, b_rsp_stable, b_launch;
  logic [7:0] a_chal, b_chal;
  puf_state_e a_state, b_state;

  puf_challenge_sequencer #(.CHAL_W(8), .SETTLE_CYCLES(3), .VOTES(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(sw_req_valid), .req_ready(a_req_ready), .req_chal(8'h3c),
    .rsp_valid(a_rsp_valid), .rsp_ready(1'b1),
    .rsp_bit(a_rsp_bit), .rsp_stable(a_rsp_stable),
    .puf_chal(a_chal), .puf_launch(a_launch), .puf_resp(a_launch),
    .dbg_state(a_state)
  );

  puf_challenge_sequencer #(.CHAL_W(8), .SETTLE_CYCLES(3), .VOTES(15)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(sw_req_valid), .req_ready(b_req_ready), .req_chal(8'hc3),
    .rsp_valid(b_rsp_valid), .rsp_ready(1'b1),
    .rsp_bit(b_rsp_bit), .rsp_stable(b_rsp_stable),
    .puf_chal(b_chal), .puf_launch(b_launch), .puf_resp(b_launch),
    .dbg_state(b_state)
  );

  // ---------------- behavioural PUF model ----------------
  logic [4:0] pattern = '0;
  int         pat_idx = 0;
  logic       model_val = 1'b0;
  assign puf_resp = puf_launch & model_val;

  always @(posedge puf_launch) begin
    model_val = (pat_idx < 5) ? pattern[pat_idx] : 1'b0;
    pat_idx   = pat_idx + 1;
  end

  // ---------------- counters / scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // launch pulse monitor: rising-edge count and high length
  int   rise_cnt = 0;
  int   run_len = 0;
  logic launch_prev = 1'b0;
  logic len_chk_en = 1'b1;

  always @(negedge clk) begin
    if (puf_launch && !launch_prev) begin
      rise_cnt = rise_cnt + 1;
      run_len  = 1;
    end else if (puf_launch) begin
      run_len = run_len + 1;
    end else if (launch_prev && len_chk_en) begin
      check("launch_high_len", 64'(run_len), 64'd8);
    end
    launch_prev = puf_launch;
  end

  // ---------------- driver tasks ----------------
  task automatic set_pattern(input logic [4:0] p);
    pattern  = p;
    pat_idx  = 0;
    rise_cnt = 0;
  endtask

  task automatic push_exp(input logic [4:0] p);
    int ones;
    ones = $countones(p);
    exp_q.push_back({(ones > 2) ? 1'b1 : 1'b0, (ones == 0 || ones == 5) ? 1'b1 : 1'b0});
  endtask

  // Called at a negedge; returns at the negedge of cycle 1 after the accept edge.
  task automatic accept_req(input logic [31:0] chal);
    logic ok;
    ok = 1'b0;
    req_valid = 1'b1;
    req_chal  = chal;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (req_ready) ok = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("accept_handshake", 64'(ok), 64'd1);
    check("puf_chal_capture", 64'(puf_chal), 64'(chal));
  endtask

  // Waits for rsp_valid; latency is counted in cycles after the accept edge.
  task automatic wait_rsp(input int exp_lat);
    int cyc;
    logic [1:0] e;
    cyc = 1;
    while (!rsp_valid && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check("rsp_latency", 64'(cyc), 64'(exp_lat));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rsp_bit_stable", 64'({rsp_bit, rsp_stable}), 64'(e));
    end else begin
      check("scoreboard_empty", 64'd1, 64'd0);
    end
  endtask

  task automatic finish_rsp();
    @(negedge clk);
    check("rsp_valid_one_cycle", 64'(rsp_valid), 64'd0);
    check("req_ready_returns", 64'(req_ready), 64'd1);
  endtask

  task automatic run_req(input logic [31:0] chal, input logic [4:0] p);
    set_pattern(p);
    push_exp(p);
    accept_req(chal);
    wait_rsp(86);
    check("launch_edges", 64'(rise_cnt), 64'd5);
    finish_rsp();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int   n;
    logic saw_rsp;
    int   lat_a, lat_b;

    // reset then idle
    repeat (3) @(negedge clk);
    check("rst_puf_launch", 64'(puf_launch), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_req_ready", 64'(req_ready), 64'd1);
    check("idle_rsp_valid", 64'(rsp_valid), 64'd0);
    check("idle_rsp_bit", 64'(rsp_bit), 64'd0);
    check("idle_rsp_stable", 64'(rsp_stable), 64'd0);
    check("idle_puf_chal", 64'(puf_chal), 64'd0);
    check("idle_state", 64'(dbg_state), 64'(ST_IDLE));
    check("idle_sweep_states", 64'({a_state, b_state}), 64'({ST_IDLE, ST_IDLE}));
    rise_cnt = 0;
    repeat (100) @(negedge clk);
    check("idle_no_launch", 64'(rise_cnt), 64'd0);
    check("idle_launch_low", 64'(puf_launch), 64'd0);

    // single request, PUF always 1
    run_req(32'hAAAAAAAA, 5'b11111);
    // noisy votes
    run_req($urandom(), 5'b10101);
    run_req($urandom(), 5'b00100);
    run_req($urandom(), 5'b00000);

    // backpressure
    rsp_ready = 1'b0;
    set_pattern(5'b11111);
    push_exp(5'b11111);
    accept_req(32'hAAAAAAAA);
    wait_rsp(86);
    req_valid = 1'b1;
    req_chal  = 32'h55555555;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_rsp_held", 64'({rsp_valid, rsp_bit, rsp_stable}), 64'b111);
      check("bp_req_ready", 64'(req_ready), 64'd0);
      check("bp_puf_chal", 64'(puf_chal), 64'hAAAAAAAA);
    end
    set_pattern(5'b01101);
    push_exp(5'b01101);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 64'(rsp_valid), 64'd0);
    check("bp_release_ready", 64'(req_ready), 64'd1);
    check("bp_chal_not_yet", 64'(puf_chal), 64'hAAAAAAAA);
    @(negedge clk);
    req_valid = 1'b0;
    check("bp_late_accept", 64'(puf_chal), 64'h55555555);
    check("bp_busy", 64'(req_ready), 64'd0);
    wait_rsp(86);
    finish_rsp();

    // reset during the third launch
    set_pattern(5'b11111);
    accept_req($urandom());
    n = 0;
    while (rise_cnt < 3 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("third_launch_seen", 64'(rise_cnt), 64'd3);
    @(negedge clk);
    len_chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_launch", 64'(puf_launch), 64'd0);
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midrst_idle", 64'(dbg_state), 64'(ST_IDLE));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    saw_rsp = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1'b1;
    end
    len_chk_en = 1'b1;
    check("midrst_no_rsp", 64'(saw_rsp), 64'd0);
    check("midrst_ready", 64'(req_ready), 64'd1);
    run_req(32'h12345678, 5'b00001);

    // parameter sweep
    lat_a = 0;
    lat_b = 0;
    sw_req_valid = 1'b1;
    check("sweep_ready", 64'({a_req_ready, b_req_ready}), 64'b11);
    @(posedge clk);
    @(negedge clk);
    sw_req_valid = 1'b0;
    for (int c = 1; c < 200 && lat_b == 0; c++) begin
      if (a_rsp_valid && lat_a == 0) begin
        lat_a = c;
        check("sweep_v1_resp", 64'({a_rsp_bit, a_rsp_stable}), 64'b11);
      end
      if (b_rsp_valid && lat_b == 0) begin
        lat_b = c;
        check("sweep_v15_resp", 64'({b_rsp_bit, b_rsp_stable}), 64'b11);
      end
      if (lat_b == 0) @(negedge clk);
    end
    check("sweep_v1_latency", 64'(lat_a), 64'd8);
    check("sweep_v15_latency", 64'(lat_b), 64'd106);
    check("sweep_chal", 64'({a_chal, b_chal}), 64'h3cc3);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/puf_challenge_sequencer.md
# puf_challenge_sequencer

Sequencer sitting between a challenge source and the XOR-chained arbiter PUF array. Accepts one challenge per request, drives it onto the PUF challenge bus, and issues repeated precharge/launch cycles on the shared start signal (tied to both `in_X` and `in_Y`). Each launch's arbiter response is sampled through a synchronizer, and the block returns a majority-voted response bit plus a stability flag. It is the only block that toggles the PUF launch net.

## Interface
Parameters:
- `CHAL_W`, 32, challenge width; equals PUF stage count `le`.
- `SETTLE_CYCLES`, 8, clock cycles per precharge phase and per launch phase; legal range 3..255.
- `VOTES`, 5, launches per challenge; odd, legal range 1..15.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: challenge request valid.
- `req_ready` out 1: block idle, can accept a request.
- `req_chal` in CHAL_W: challenge, captured on handshake.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer accepts response.
- `rsp_bit` out 1: majority-voted response.
- `rsp_stable` out 1: all votes agreed.
- `puf_chal` out CHAL_W: registered challenge to PUF `Chal`.
- `puf_launch` out 1: registered start edge to PUF `in_X`/`in_Y`.
- `puf_resp` in 1: PUF `out_Q`, asynchronous to `clk`.

## Operation
- States: IDLE, PRECHARGE, LAUNCH, SAMPLE, RESP.
- IDLE: `req_ready`=1. On `req_valid && req_ready`:
  - capture `req_chal` into `puf_chal`;
  - clear vote and ones counters;
  - go to PRECHARGE.
- PRECHARGE: `puf_launch`=0 for SETTLE_CYCLES cycles, then go to LAUNCH.
- LAUNCH: `puf_launch`=1 for SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE (1 cycle):
  - add the synchronized response to the ones counter; increment the vote counter.
  - If vote counter reaches VOTES, go to RESP; otherwise go to PRECHARGE.
  - `puf_launch` drops to 0 on the transition out of SAMPLE.
- RESP:
  - `rsp_valid`=1; `rsp_bit` = (ones > VOTES/2); `rsp_stable` = (ones==0 || ones==VOTES).
  - Outputs are registered and held stable until `rsp_valid && rsp_ready`, then go to IDLE.
- `puf_chal` changes only on request accept; it is held through RESP and afterwards.
- `puf_resp` passes through a 2-flop synchronizer. SETTLE_CYCLES ≥ 3 guarantees the sampled value reflects the current launch.
- Widths:
  - Phase counter: 8 bits.
  - Vote and ones counters: 4 bits, no wrap possible within legal VOTES.
- `req_valid` outside IDLE is ignored: no queueing and no overwrite of `puf_chal`.

## Timing
- Reset values: `req_ready`=1 (state IDLE), `rsp_valid`=0, `rsp_bit`=0, `rsp_stable`=0, `puf_chal`=0, `puf_launch`=0, synchronizer flops=0, all counters=0.
- Accept at edge 0. First PRECHARGE occupies cycles 1..S, LAUNCH S+1..2S, SAMPLE 2S+1 (S=SETTLE_CYCLES).
- Each vote takes 2S+1 cycles. `rsp_valid` rises at cycle VOTES·(2S+1)+1; with defaults that is cycle 86.
- With `rsp_ready` held 1: `rsp_valid` is high for exactly one cycle, and `req_ready` returns the next cycle.
- Minimum accept-to-accept spacing: VOTES·(2S+1)+2 cycles.
- Reset mid-operation:
  - `puf_launch` and `rsp_valid` deassert immediately (asynchronously).
  - Partial votes are discarded; no response is issued.
  - After release, the block is in IDLE.
- `rsp_ready` asserted outside RESP has no effect.

## Structure
- Package `puf_ctrl_pkg`:
  - state enum typedef (IDLE, PRECHARGE, LAUNCH, SAMPLE, RESP);
  - default parameter constants;
  - phase-counter width constant (8).
- Sub-module `puf_resp_sync`: 2-flop synchronizer, async active-low reset, 1-bit.
- Top holds the FSM, counters and output registers. The PUF array is instantiated beside the block, not inside it.

## Test plan
- Reset then idle: after `rst_n` release, `req_ready`=1 and `rsp_valid`=0; `puf_launch` stays 0 for 100 cycles with no request.
- Single request, defaults: `req_chal`=32'hAAAAAAAA, behavioural PUF model returns 1 every launch. Required: `rsp_valid` at cycle 86, `rsp_bit`=1, `rsp_stable`=1; exactly 5 rising edges on `puf_launch`, each 8 cycles high.
- Noisy votes: model returns 1,0,1,0,1 → `rsp_bit`=1, `rsp_stable`=0. Model returns 0,0,1,0,0 → `rsp_bit`=0, `rsp_stable`=0.
- Backpressure: `rsp_ready`=0 for 20 cycles in RESP. `rsp_valid`, `rsp_bit` and `rsp_stable` are held; `req_valid` with `req_chal`=32'h55555555 is ignored and `puf_chal` stays 32'hAAAAAAAA. After `rsp_ready`=1, that request is accepted one cycle after `req_ready` returns.
- Reset mid-LAUNCH: assert `rst_n`=0 during the third launch. `puf_launch`=0 and `rsp_valid`=0 immediately; after release, a fresh request completes normally with 5 fresh votes.
- Parameter sweep: SETTLE_CYCLES=3 with VOTES=1 → `rsp_valid` at cycle 8; SETTLE_CYCLES=3 with VOTES=15 → `rsp_valid` at cycle 106.
